// File: rtl/data_memory_ctrl_if.sv
// ============================================================
// Module : data_memory_ctrl_if
// Desc   : Request/response bus for the data memory controller
// Rev    : 1.0
// ============================================================
`default_nettype none

interface data_memory_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/data_memory_ctrl.sv
// ============================================================
// Module : data_memory_ctrl
// Desc   : Byte/half/word data memory, valid/ready request, wait states
// Rev    : 1.0
// ============================================================
`default_nettype none

module data_memory_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 32
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  data_memory_ctrl_if.slave bus
);
  localparam int              c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_BYTES     = (ADDR_W+1)'(DEPTH * 4);
  localparam logic [3:0]      c_WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [1:0]      c_SZ_B      = 2'b00;
  localparam logic [1:0]      c_SZ_H      = 2'b01;
  localparam logic [1:0]      c_SZ_W      = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic              r_unsigned;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;
  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_commit;
  logic              w_err;
  logic              w_write;
  logic              w_unsigned;
  logic [1:0]        w_size;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_wdata;
  logic [c_IDX_W-1:0] w_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_wlanes;
  logic [31:0]       w_word;
  logic [31:0]       w_shift;
  logic [31:0]       w_load;

  assign bus.req_ready = rst_n && (r_state == S_IDLE);
  assign w_accept      = bus.req_valid && bus.req_ready;

  // In IDLE the request is still on the bus; a zero-wait commit uses it directly.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_write    = bus.req_write;
      w_unsigned = bus.req_unsigned;
      w_size     = bus.req_size;
      w_addr     = bus.req_addr;
      w_wdata    = bus.req_wdata;
    end else begin
      w_write    = r_write;
      w_unsigned = r_unsigned;
      w_size     = r_size;
      w_addr     = r_addr;
      w_wdata    = r_wdata;
    end
  end

  always_comb begin
    w_err = 1'b0;
    case (w_size)
      c_SZ_B:  w_err = 1'b0;
      c_SZ_H:  w_err = w_addr[0];
      c_SZ_W:  w_err = |w_addr[1:0];
      default: w_err = 1'b1;
    endcase
    if ({1'b0, w_addr} >= c_BYTES) w_err = 1'b1;
  end

  assign w_commit = (r_state == S_IDLE && w_accept && !w_err && (WAIT_STATES == 0))
                 || (rst_n && r_state == S_WAIT && r_cnt == 4'd0);

  assign w_idx = w_addr[c_IDX_W+1:2];

  // Store data is replicated across lanes so the byte enables alone select placement.
  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = w_wdata;
    case (w_size)
      c_SZ_B: begin
        w_be     = 4'b0001 << w_addr[1:0];
        w_wlanes = {4{w_wdata[7:0]}};
      end
      c_SZ_H: begin
        w_be     = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{w_wdata[15:0]}};
      end
      c_SZ_W:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_addr[1:0], 3'b000};

  always_comb begin
    case (w_size)
      c_SZ_B:  w_load = {{24{w_shift[7] & ~w_unsigned}}, w_shift[7:0]};
      c_SZ_H:  w_load = {{16{w_shift[15] & ~w_unsigned}}, w_shift[15:0]};
      default: w_load = w_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_write) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wlanes[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_write    <= bus.req_write;
      r_unsigned <= bus.req_unsigned;
      r_size     <= bus.req_size;
      r_addr     <= bus.req_addr;
      r_wdata    <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_err) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'd0;
            end else if (w_commit) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_rdata <= w_write ? 32'd0 : w_load;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= w_write ? 32'd0 : w_load;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
// ============================================================
// Module : tb_data_memory_ctrl
// Desc   : Directed bench with a byte-array reference model
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_data_memory_ctrl;
  localparam int DEPTH = 256;
  localparam int WS    = 2;
  localparam int AW    = 32;

  logic clk = 1'b0;
  logic rst_n;

  data_memory_ctrl_if #(.ADDR_W(AW)) bus();

  data_memory_ctrl #(
    .DEPTH      (DEPTH),
    .WAIT_STATES(WS),
    .ADDR_W     (AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  // Reference model: byte-addressed memory, response due a fixed number of edges after accept.
  logic [7:0]  mb [DEPTH*4];
  bit          started = 1'b0;
  longint      cyc     = 0;
  longint      m_due   = 0;
  bit          m_pend  = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  bit          m_err   = 1'b0;
  bit          q_write, q_uns, q_err;
  logic [1:0]  q_size;
  logic [31:0] q_addr, q_wdata;

  always @(posedge clk) begin
    bit acc;
    int nb;
    logic [31:0] v;
    started = 1'b1;
    cyc++;
    if (!rst_n) begin
      m_pend  = 1'b0;
      m_valid = 1'b0;
      m_rdata = 32'd0;
      m_err   = 1'b0;
    end else begin
      acc     = bus.req_valid && !m_pend && !m_valid;
      m_valid = 1'b0;
      if (acc) begin
        q_write = bus.req_write;
        q_uns   = bus.req_unsigned;
        q_size  = bus.req_size;
        q_addr  = bus.req_addr;
        q_wdata = bus.req_wdata;
        nb      = (q_size == 2'd0) ? 1 : (q_size == 2'd1) ? 2 : 4;
        q_err   = (q_size == 2'd3) || ((q_addr % nb) != 0) || (q_addr >= DEPTH*4);
        m_due   = cyc + (q_err ? 0 : WS);
        m_pend  = 1'b1;
      end
      if (m_pend && cyc == m_due) begin
        nb = (q_size == 2'd0) ? 1 : (q_size == 2'd1) ? 2 : 4;
        m_pend  = 1'b0;
        m_valid = 1'b1;
        m_err   = q_err;
        m_rdata = 32'd0;
        if (!q_err && q_write) begin
          for (int i = 0; i < nb; i++) mb[q_addr + i] = q_wdata[8*i +: 8];
        end else if (!q_err) begin
          v = 32'd0;
          for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[q_addr + i];
          if (!q_uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
          m_rdata = v;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cmp req_ready", {31'd0, bus.req_ready}, {31'd0, rst_n && !m_pend && !m_valid});
      chk("cmp rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_valid});
      chk("cmp rsp_rdata", bus.rsp_rdata, m_rdata);
      chk("cmp rsp_err",   {31'd0, bus.rsp_err},   {31'd0, m_err});
    end
  end

  task automatic drive_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
    bit seen;
    @(posedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.req_ready) seen = 1'b1;
    end
    if (!seen) chk("ready timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    // Scramble the bus while the request is in flight; none of it may be used.
    bus.req_valid    = 1'b0;
    bus.req_write    = ~wr;
    bus.req_size     = 2'b11;
    bus.req_unsigned = ~uns;
    bus.req_addr     = addr ^ 32'h0000_0004;
    bus.req_wdata    = 32'hA5A5_A5A5;
  endtask

  task automatic req(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    bit seen;
    int k;
    drive_req(wr, sz, uns, addr, wd);
    seen = 1'b0;
    k    = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        seen = 1'b1;
        k    = i;
      end
    end
    chk({name, " latency"}, 32'(k), 32'(exp_lat));
    chk({name, " rdata"}, bus.rsp_rdata, exp_rd);
    chk({name, " err"}, {31'd0, bus.rsp_err}, {31'd0, exp_err});
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b1;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_wdata    = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      chk("reset req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("reset rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("reset rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("reset rsp_err",   {31'd0, bus.rsp_err},   32'd0);
    end
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("ready after release", {31'd0, bus.req_ready}, 32'd1);

    req("sw 10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3);
    req("lw 10a", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEAD_BEEF, 1'b0, 3);
    req("sb 13",  1'b1, 2'b00, 1'b0, 32'h13, 32'h80,       32'h0000_0000, 1'b0, 3);
    req("lw 10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h80AD_BEEF, 1'b0, 3);
    req("lb 13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFF_FF80, 1'b0, 3);
    req("lbu 13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h0000_0080, 1'b0, 3);
    req("sh 12",  1'b1, 2'b01, 1'b0, 32'h12, 32'h1234,     32'h0000_0000, 1'b0, 3);
    req("lw 10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1234_BEEF, 1'b0, 3);
    req("lhu 12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h0000_1234, 1'b0, 3);
    req("sh 10",  1'b1, 2'b01, 1'b0, 32'h10, 32'hF00D,     32'h0000_0000, 1'b0, 3);
    req("lh 10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'hFFFF_F00D, 1'b0, 3);
    req("lw 10d", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h1234_F00D, 1'b0, 3);

    req("err lw 11",   1'b0, 2'b10, 1'b0, 32'h11,  32'h0, 32'h0, 1'b1, 1);
    req("err sw 12",   1'b1, 2'b10, 1'b0, 32'h12,  32'h0, 32'h0, 1'b1, 1);
    req("lw 10e",      1'b0, 2'b10, 1'b0, 32'h10,  32'h0, 32'h1234_F00D, 1'b0, 3);
    req("err lw 400",  1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1);
    req("err size 11", 1'b0, 2'b11, 1'b0, 32'h10,  32'h0, 32'h0, 1'b1, 1);
    req("err lh 13",   1'b0, 2'b01, 1'b0, 32'h13,  32'h0, 32'h0, 1'b1, 1);

    req("sw 20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 3);
    drive_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h55);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midop rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req("lw 20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0000_0000, 1'b0, 3);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised data memory for the MIPS datapath, replacing the fixed 32-word, word-only, single-cycle memory.
- Supports byte, halfword and word accesses with sign or zero extension, and little-endian byte lanes.
- Uses a valid/ready request handshake and a configurable number of wait states.
- Reports misaligned and out-of-range accesses on an error flag instead of corrupting memory.

Parameters:
- DEPTH, 256: memory size in 32-bit words; legal byte addresses are 0 .. DEPTH*4-1.
- WAIT_STATES, 2: extra cycles between request acceptance and commit; legal range 0..15.
- ADDR_W, 32: width of the byte address port.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- req_valid  input  1  a request is present on the req_* fields.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  load only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result (extended); 0 for stores and errors.
- rsp_err  output  1  access was misaligned, out of range, or had an illegal size.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE, wait counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready is forced to 0 while rst_n is low.
  - Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = 1 only in IDLE (with rst_n high).
- Acceptance: req_valid && req_ready at a clk edge.
  - req_write, req_size, req_unsigned, req_addr and req_wdata are latched at that edge.
  - Later changes on the inputs are ignored until the next acceptance.
- Error check, performed on the latched request:
  - req_size = 11 is an error.
  - Halfword with addr[0] = 1 is an error.
  - Word with addr[1:0] != 0 is an error.
  - addr >= DEPTH*4 is an error.
  - On error: go directly to RESP, skipping WAIT. No memory write. rsp_err = 1, rsp_rdata = 0.
- Legal request, WAIT_STATES = 0: IDLE -> RESP.
- Legal request, WAIT_STATES > 0: IDLE -> WAIT.
  - The counter loads WAIT_STATES-1 and decrements each cycle.
  - WAIT -> RESP on the edge where the counter is 0.
- Commit edge (the edge entering RESP):
  - A store writes only its addressed lanes.
  - A load samples the word and extends the addressed lanes.
- Response: rsp_valid = 1 for exactly the RESP cycle.
  - rsp_rdata and rsp_err are registered and hold their values until the next response.
- RESP -> IDLE unconditionally. No response back-pressure.
- Latency: rsp_valid rises WAIT_STATES+1 cycles after the acceptance edge (1 cycle for errors).
- Throughput: one access per WAIT_STATES+2 cycles.
- Byte lanes, little-endian: lane k = bits [8k+7:8k], k = addr[1:0].
  - Byte store writes req_wdata[7:0] to lane k.
  - Halfword store writes req_wdata[15:0] to lanes 2*addr[1] and 2*addr[1]+1.
  - Word store writes all four lanes.
- Load extension: bit 7 (byte) or bit 15 (halfword) is replicated into the upper bits unless req_unsigned = 1. Word loads ignore req_unsigned.
- Word index = addr[ADDR_W-1:2].
- Reset mid-operation: a request accepted but not yet committed is dropped. No write occurs and no rsp_valid is produced.

Test Plan:
- Reset: hold rst_n low 2 cycles with req_valid = 1 -> req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; req_ready = 1 the cycle after release.
- Word round trip (WAIT_STATES = 2): sw 0xDEADBEEF @0x10, then lw @0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, rsp_valid exactly 3 cycles after each accept, 1 cycle wide. Inputs toggled during WAIT have no effect.
- Byte lanes: sb 0x80 @0x13 -> lw @0x10 = 0x80ADBEEF; lb signed @0x13 = 0xFFFFFF80; lbu @0x13 = 0x00000080.
- Halfwords: sh 0x1234 @0x12 -> lw @0x10 = 0x1234BEEF, lhu @0x12 = 0x00001234. Then sh 0xF00D @0x10 -> lh @0x10 = 0xFFFFF00D, lw @0x10 = 0x1234F00D.
- Errors:
  - lw @0x11 -> rsp_err = 1, rsp_rdata = 0, rsp_valid 1 cycle after accept.
  - sw 0x0 @0x12 (misaligned word) -> rsp_err = 1; lw @0x10 afterwards is still 0x1234F00D.
  - lw @DEPTH*4 (0x400) -> rsp_err = 1.
  - req_size = 11 -> rsp_err = 1.
- Reset mid-op: sw 0x0 @0x20 completes; then sw 0x55 @0x20, pull rst_n low during WAIT -> no rsp_valid. After release, lw @0x20 = 0x00000000.
